// File: rtl/nios_sys_pio_pkg.sv
// Shared register map and sizing helpers for the keypad PIO.
// Pure declarations, no logic; no flow control.
package nios_sys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Counter only has to hold DEBOUNCE_CYCLES-1, never less than one bit.
  function automatic int db_cnt_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/nios_sys_pio_debounce.sv
// One input bit: 2-flop sync, saturating debounce counter, rising-edge pulse.
// Latency 2 + DEBOUNCE_CYCLES cycles for a stable input; no backpressure.
module nios_sys_pio_debounce
  import nios_sys_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb,
  output logic rise
);

  localparam int             CW      = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          accept;

  // rise is combinational so edgecapture sets on the same edge deb updates.
  assign accept = (sync2 != deb) && (cnt == CNT_MAX);
  assign rise   = accept && sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (accept) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nios_sys_pio_keypad_in.sv
// Avalon-MM input PIO with per-bit debounce, rising-edge capture and level irq.
// Read latency 1 cycle, zero wait states; no backpressure.
module nios_sys_pio_keypad_in
  import nios_sys_pio_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int DEBOUNCE_CYCLES = 12000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] rise;
  logic [DATA_WIDTH-1:0] irqmask;
  logic [DATA_WIDTH-1:0] edgecap;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  wr_en;
  logic                  unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    nios_sys_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .deb     (data[i]),
      .rise    (rise[i])
    );
  end

  assign wr_en = chipselect && !write_n;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux = data;
      ADDR_IRQMASK: rd_mux = irqmask;
      ADDR_EDGECAP: rd_mux = edgecap;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask  <= '0;
      edgecap  <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask <= writedata[DATA_WIDTH-1:0];
      end
      // Set is ORed in after the clear so a same-cycle edge wins.
      if (wr_en && address == ADDR_EDGECAP) begin
        edgecap <= (edgecap & ~writedata[DATA_WIDTH-1:0]) | rise;
      end else begin
        edgecap <= edgecap | rise;
      end
      readdata <= 32'(rd_mux);
      irq      <= |(edgecap & irqmask);
    end
  end

endmodule
